// File: rtl/urcpu_alu.sv
// Registered 20-bit integer ALU: one-cycle add/sub/logic/shift/compare with status flags.
// Define ALU_MULDIV_EN to implement MUL (opcode 4) and DIV (opcode 5); otherwise they are no-ops.
module urcpu_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [4:0]  instruction,
    input  logic [19:0] arg0,
    input  logic [19:0] arg1,
    input  logic        carry_in,
    output logic [19:0] res0,
    output logic [19:0] res1,
    output logic        carry_out,
    output logic        overflow_out,
    output logic        underflow_out,
    output logic        sign_out,
    output logic        zero_out
);

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,  OP_ADC = 5'd1,  OP_SUB = 5'd2,  OP_SBB = 5'd3,
        OP_MUL = 5'd4,  OP_DIV = 5'd5,  OP_AND = 5'd6,  OP_OR  = 5'd7,
        OP_XOR = 5'd8,  OP_NOT = 5'd9,  OP_SHL = 5'd10, OP_SHR = 5'd11,
        OP_SAR = 5'd12, OP_CMP = 5'd13
    } op_e;

    // {overflow, underflow} of an exact signed result against the 20-bit range
    function automatic logic [1:0] range_flags(input logic signed [21:0] v);
        range_flags = {v > 22'sd524287, v < -22'sd524288};
    endfunction

    logic signed [21:0] s_add, s_adc, s_sub, s_sbb, s_a, s_b, s_c;
    logic [20:0]        u_add, u_adc, u_sub, u_sbb;
    logic [20:0]        shl_full, shr_full;
    logic signed [20:0] sar_full;
    logic [4:0]         amt;

    logic [19:0] n_res0, n_res1;
    logic        n_carry, n_ovf, n_unf, n_sign, n_zero;
    logic        sz_from_res;

    assign s_a = $signed({{2{arg0[19]}}, arg0});
    assign s_b = $signed({{2{arg1[19]}}, arg1});
    assign s_c = $signed({21'd0, carry_in});

    assign s_add = s_a + s_b;
    assign s_adc = s_a + s_b + s_c;
    assign s_sub = s_a - s_b;
    assign s_sbb = s_a - s_b - s_c;

    // Bit 20 of the 21-bit unsigned result is the carry, or the borrow after wraparound
    assign u_add = {1'b0, arg0} + {1'b0, arg1};
    assign u_adc = {1'b0, arg0} + {1'b0, arg1} + {20'd0, carry_in};
    assign u_sub = {1'b0, arg0} - {1'b0, arg1};
    assign u_sbb = {1'b0, arg0} - {1'b0, arg1} - {20'd0, carry_in};

    // Shifting through one extra bit position exposes the last bit shifted out
    assign amt      = arg1[4:0];
    assign shl_full = {1'b0, arg0} << amt;
    assign shr_full = {arg0, 1'b0} >> amt;
    assign sar_full = $signed({arg0, 1'b0}) >>> amt;

`ifdef ALU_MULDIV_EN
    logic [39:0] prod;
    logic [19:0] quo, rem;
    assign prod = {20'd0, arg0} * {20'd0, arg1};
    assign quo  = (arg1 == 20'd0) ? 20'hFFFFF : arg0 / arg1;
    assign rem  = (arg1 == 20'd0) ? arg0 : arg0 % arg1;
`endif

    always_comb begin
        n_res0      = res0;
        n_res1      = res1;
        n_carry     = carry_out;
        n_ovf       = overflow_out;
        n_unf       = underflow_out;
        n_sign      = sign_out;
        n_zero      = zero_out;
        sz_from_res = 1'b1;
        case (instruction)
            OP_ADD: begin
                n_res0 = u_add[19:0]; n_res1 = '0; n_carry = u_add[20];
                {n_ovf, n_unf} = range_flags(s_add);
            end
            OP_ADC: begin
                n_res0 = u_adc[19:0]; n_res1 = '0; n_carry = u_adc[20];
                {n_ovf, n_unf} = range_flags(s_adc);
            end
            OP_SUB: begin
                n_res0 = u_sub[19:0]; n_res1 = '0; n_carry = u_sub[20];
                {n_ovf, n_unf} = range_flags(s_sub);
            end
            OP_SBB: begin
                n_res0 = u_sbb[19:0]; n_res1 = '0; n_carry = u_sbb[20];
                {n_ovf, n_unf} = range_flags(s_sbb);
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                n_res0 = prod[19:0]; n_res1 = prod[39:20];
                n_carry = |prod[39:20]; n_ovf = |prod[39:20]; n_unf = 1'b0;
            end
            OP_DIV: begin
                n_res0 = quo; n_res1 = rem; n_carry = 1'b0;
                n_ovf = (arg1 == 20'd0); n_unf = 1'b0;
            end
`endif
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                n_res1 = '0; n_carry = 1'b0; n_ovf = 1'b0; n_unf = 1'b0;
                case (instruction)
                    OP_AND:  n_res0 = arg0 & arg1;
                    OP_OR:   n_res0 = arg0 | arg1;
                    OP_XOR:  n_res0 = arg0 ^ arg1;
                    default: n_res0 = ~arg0;
                endcase
            end
            OP_SHL, OP_SHR, OP_SAR: begin
                n_res1 = '0; n_ovf = 1'b0; n_unf = 1'b0;
                if (amt >= 5'd20) begin
                    n_carry = 1'b0;
                    n_res0  = (instruction == OP_SAR) ? {20{arg0[19]}} : 20'd0;
                end else if (instruction == OP_SHL) begin
                    n_carry = shl_full[20]; n_res0 = shl_full[19:0];
                end else if (instruction == OP_SHR) begin
                    n_carry = shr_full[0];  n_res0 = shr_full[20:1];
                end else begin
                    n_carry = sar_full[0];  n_res0 = sar_full[20:1];
                end
            end
            OP_CMP: begin
                sz_from_res = 1'b0;
                n_carry = u_sub[20];
                {n_ovf, n_unf} = range_flags(s_sub);
                n_sign = u_sub[19];
                n_zero = (u_sub[19:0] == 20'd0);
            end
            default: sz_from_res = 1'b0;
        endcase
        if (sz_from_res) begin
            n_sign = n_res0[19];
            n_zero = (n_res0 == 20'd0);
        end
    end

    // Output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res0          <= '0;
            res1          <= '0;
            carry_out     <= 1'b0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
            sign_out      <= 1'b0;
            zero_out      <= 1'b0;
        end else if (enable) begin
            res0          <= n_res0;
            res1          <= n_res1;
            carry_out     <= n_carry;
            overflow_out  <= n_ovf;
            underflow_out <= n_unf;
            sign_out      <= n_sign;
            zero_out      <= n_zero;
        end
    end

endmodule

// File: tb/tb_urcpu_alu.sv
// Directed-vector bench for urcpu_alu; MUL/DIV vectors apply when ALU_MULDIV_EN is defined.
module tb_urcpu_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [4:0]  instruction;
    logic [19:0] arg0, arg1;
    logic        carry_in;
    logic [19:0] res0, res1;
    logic        carry_out, overflow_out, underflow_out, sign_out, zero_out;

    int n_chk = 0;
    int n_bad = 0;

    urcpu_alu dut (
        .clk(clk), .rst(rst), .enable(enable), .instruction(instruction),
        .arg0(arg0), .arg1(arg1), .carry_in(carry_in),
        .res0(res0), .res1(res1), .carry_out(carry_out),
        .overflow_out(overflow_out), .underflow_out(underflow_out),
        .sign_out(sign_out), .zero_out(zero_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [19:0] r0, input logic [19:0] r1,
                              input logic c, input logic o, input logic u,
                              input logic s, input logic z);
        check({tag, ".res0"}, res0, r0);
        check({tag, ".res1"}, res1, r1);
        check({tag, ".carry"}, {19'd0, carry_out}, {19'd0, c});
        check({tag, ".ovf"}, {19'd0, overflow_out}, {19'd0, o});
        check({tag, ".unf"}, {19'd0, underflow_out}, {19'd0, u});
        check({tag, ".sign"}, {19'd0, sign_out}, {19'd0, s});
        check({tag, ".zero"}, {19'd0, zero_out}, {19'd0, z});
    endtask

    task automatic exec(input logic [4:0] op, input logic [19:0] a, input logic [19:0] b,
                        input logic cin, input logic en);
        @(negedge clk);
        instruction = op; arg0 = a; arg1 = b; carry_in = cin; enable = en;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; instruction = '0; arg0 = '0; arg1 = '0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_all("reset", 20'h0, 20'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        exec(5'd0, 20'h7FFFF, 20'h00001, 0, 1);
        expect_all("add_ovf", 20'h80000, 20'h0, 0, 1, 0, 1, 0);

        exec(5'd1, 20'hFFFFF, 20'h00000, 1, 1);
        expect_all("adc_carry", 20'h00000, 20'h0, 1, 0, 0, 0, 1);

        exec(5'd2, 20'd5, 20'd7, 0, 1);
        expect_all("sub_borrow", 20'hFFFFE, 20'h0, 1, 0, 0, 1, 0);

        exec(5'd13, 20'd9, 20'd9, 0, 1);
        expect_all("cmp_eq", 20'hFFFFE, 20'h0, 0, 0, 0, 0, 1);

        exec(5'd3, 20'h80000, 20'h00000, 1, 1);
        expect_all("sbb_unf", 20'h7FFFF, 20'h0, 0, 0, 1, 0, 0);

        exec(5'd2, 20'd5, 20'd7, 0, 1);
        exec(5'd6, 20'hF0F0F, 20'h0FF0F, 0, 1);
        expect_all("and", 20'h00F0F, 20'h0, 0, 0, 0, 0, 0);
        exec(5'd7, 20'h12340, 20'h0000F, 0, 1);
        expect_all("or", 20'h1234F, 20'h0, 0, 0, 0, 0, 0);
        exec(5'd8, 20'hFFFFF, 20'h0F0F0, 0, 1);
        expect_all("xor", 20'hF0F0F, 20'h0, 0, 0, 0, 1, 0);
        exec(5'd9, 20'h00000, 20'h12345, 0, 1);
        expect_all("not", 20'hFFFFF, 20'h0, 0, 0, 0, 1, 0);

        exec(5'd10, 20'h80001, 20'd1, 0, 1);
        expect_all("shl1", 20'h00002, 20'h0, 1, 0, 0, 0, 0);
        exec(5'd12, 20'h80000, 20'd19, 0, 1);
        expect_all("sar19", 20'hFFFFF, 20'h0, 0, 0, 0, 1, 0);
        exec(5'd11, 20'h80000, 20'd25, 0, 1);
        expect_all("shr25", 20'h00000, 20'h0, 0, 0, 0, 0, 1);
        exec(5'd11, 20'h00003, 20'd1, 0, 1);
        expect_all("shr1", 20'h00001, 20'h0, 1, 0, 0, 0, 0);
        exec(5'd10, 20'h00005, 20'd0, 0, 1);
        expect_all("shl0", 20'h00005, 20'h0, 0, 0, 0, 0, 0);
        exec(5'd12, 20'h80000, 20'd20, 0, 1);
        expect_all("sar20", 20'hFFFFF, 20'h0, 0, 0, 0, 1, 0);
        exec(5'd10, 20'h00001, 20'd19, 0, 1);
        expect_all("shl19", 20'h80000, 20'h0, 0, 0, 0, 1, 0);

`ifdef ALU_MULDIV_EN
        exec(5'd4, 20'h00400, 20'h00800, 0, 1);
        expect_all("mul", 20'h00000, 20'h00002, 1, 1, 0, 0, 1);
        exec(5'd5, 20'd100, 20'd7, 0, 1);
        expect_all("div", 20'd14, 20'd2, 0, 0, 0, 0, 0);
        exec(5'd5, 20'd5, 20'd0, 0, 1);
        expect_all("div0", 20'hFFFFF, 20'd5, 0, 1, 0, 1, 0);
`else
        exec(5'd0, 20'd10, 20'd20, 0, 1);
        exec(5'd4, 20'h00400, 20'h00800, 0, 1);
        expect_all("mul_noop", 20'd30, 20'h0, 0, 0, 0, 0, 0);
        exec(5'd5, 20'd100, 20'd7, 0, 1);
        expect_all("div_noop", 20'd30, 20'h0, 0, 0, 0, 0, 0);
`endif

        exec(5'd0, 20'd3, 20'd4, 0, 1);
        expect_all("add", 20'd7, 20'h0, 0, 0, 0, 0, 0);
        exec(5'd2, 20'd1, 20'd9, 1, 0);
        exec(5'd9, 20'd0, 20'd0, 0, 0);
        expect_all("hold_en0", 20'd7, 20'h0, 0, 0, 0, 0, 0);
        exec(5'd20, 20'hFFFFF, 20'hFFFFF, 1, 1);
        expect_all("hold_rsvd", 20'd7, 20'h0, 0, 0, 0, 0, 0);

        exec(5'd2, 20'd5, 20'd7, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        expect_all("async_rst", 20'h0, 20'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        exec(5'd0, 20'd1, 20'd1, 0, 1);
        expect_all("post_rst", 20'd2, 20'h0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
